// File: rtl/branch_pkg.sv
// Shared types for the branch SPR write arbiter: SPR selector, arbiter states,
// and the default SPR width.
package branch_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    SPR_NONE = 2'b00,
    SPR_LR   = 2'b01,
    SPR_CTR  = 2'b10,
    SPR_TAR  = 2'b11
  } spr_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PEND  = 2'b01,
    DRAIN = 2'b10
  } arb_state_t;

endpackage

// File: rtl/spr_write_buffer.sv
// One-entry holding buffer for a move-to-SPR write, with a saturating wait
// counter that flags when the next deferral would reach MAX_WAIT.
module spr_write_buffer
  import branch_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MAX_WAIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [1:0]      i_load_sel,
  input  logic [XLEN-1:0] i_load_data,
  input  logic            i_drain,
  input  logic            i_defer,
  output logic            o_full,
  output logic [1:0]      o_sel,
  output logic [XLEN-1:0] o_data,
  output logic            o_aged
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_WAIT);
  localparam logic [3:0] AGE_TH  = 4'(MAX_WAIT - 1);

  logic            r_full;
  logic [1:0]      r_sel;
  logic [XLEN-1:0] r_data;
  logic [3:0]      r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_sel  <= 2'b00;
      r_data <= '0;
      r_cnt  <= 4'd0;
    end else begin
      // a load in the same cycle as a drain replaces the outgoing entry
      if (i_load) begin
        r_full <= 1'b1;
        r_sel  <= i_load_sel;
        r_data <= i_load_data;
        r_cnt  <= 4'd0;
      end else if (i_drain) begin
        r_full <= 1'b0;
        r_cnt  <= 4'd0;
      end else if (i_defer && (r_cnt < CNT_MAX)) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_full = r_full;
  assign o_sel  = r_sel;
  assign o_data = r_data;
  assign o_aged = r_full && (r_cnt >= AGE_TH);

endmodule

// File: rtl/branch_spr_arbiter.sv
// Arbitrates the LR/CTR/TAR write port between the branch unit and buffered
// mtspr requests. Optional perf counters under BRANCH_SPR_ARB_PERF_EN.
//
// state | meaning
// IDLE  | buffer empty
// PEND  | entry held, branch writes have priority
// DRAIN | entry forced out, branch held
module branch_spr_arbiter
  import branch_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int XLEN     = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_bu_valid,
  input  logic [1:0]      i_bu_reads_spr,
  input  logic            i_bu_wr_lr,
  input  logic [XLEN-1:0] i_bu_lr_data,
  input  logic            i_bu_wr_ctr,
  output logic            o_bu_hold,
  input  logic            i_mt_valid,
  output logic            o_mt_ready,
  input  logic [1:0]      i_mt_sel,
  input  logic [XLEN-1:0] i_mt_data,
  output logic [XLEN-1:0] o_lr,
  output logic [XLEN-1:0] o_ctr,
  output logic [XLEN-1:0] o_tar,
  output logic            err_mt_sel
`ifdef BRANCH_SPR_ARB_PERF_EN
  ,
  output logic [0:31]     o_perf_hold_cnt,
  output logic [0:31]     o_perf_drain_cnt
`endif
);

  localparam logic [XLEN-1:0] ONE = XLEN'(1);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [XLEN-1:0] r_lr;
  logic [XLEN-1:0] r_ctr;
  logic [XLEN-1:0] r_tar;
  logic            r_err;

  logic            w_full;
  logic [1:0]      w_buf_sel;
  logic [XLEN-1:0] w_buf_data;
  logic            w_aged;
  logic            w_hazard;
  logic            w_conflict;
  logic            w_entry_wr;
  logic            w_accept;
  logic            w_load;
  logic            w_defer;
  logic            w_bu_wr_lr;
  logic            w_bu_wr_ctr;

  assign w_hazard = i_bu_valid && w_full && (w_buf_sel == i_bu_reads_spr);

  // a held branch writes nothing, so a hazard never blocks the entry
  assign w_conflict = i_bu_valid && !w_hazard &&
                      (((w_buf_sel == SPR_LR)  && i_bu_wr_lr) ||
                       ((w_buf_sel == SPR_CTR) && i_bu_wr_ctr));

  assign w_accept    = i_mt_valid && o_mt_ready;
  assign w_load      = w_accept && (i_mt_sel != SPR_NONE);
  assign w_defer     = (r_state == PEND) && !w_entry_wr;
  assign w_bu_wr_lr  = i_bu_valid && !o_bu_hold && i_bu_wr_lr;
  assign w_bu_wr_ctr = i_bu_valid && !o_bu_hold && i_bu_wr_ctr;

  spr_write_buffer #(
    .XLEN     (XLEN),
    .MAX_WAIT (MAX_WAIT)
  ) u_wbuf (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_sel  (i_mt_sel),
    .i_load_data (i_mt_data),
    .i_drain     (w_entry_wr),
    .i_defer     (w_defer),
    .o_full      (w_full),
    .o_sel       (w_buf_sel),
    .o_data      (w_buf_data),
    .o_aged      (w_aged)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_load ? PEND : IDLE;
      PEND: begin
        if (w_entry_wr) begin
          w_state_nxt = w_load ? PEND : IDLE;
        end else if (w_aged) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = PEND;
        end
      end
      DRAIN:   w_state_nxt = w_load ? PEND : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_bu_hold  = 1'b0;
    w_entry_wr = 1'b0;
    case (r_state)
      PEND: begin
        o_bu_hold  = w_hazard;
        w_entry_wr = !w_conflict;
      end
      DRAIN: begin
        o_bu_hold  = 1'b1;
        w_entry_wr = 1'b1;
      end
      default: begin
        o_bu_hold  = 1'b0;
        w_entry_wr = 1'b0;
      end
    endcase
    o_mt_ready = (r_state == IDLE) || w_entry_wr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lr  <= '0;
      r_ctr <= '0;
      r_tar <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_entry_wr && (w_buf_sel == SPR_LR)) begin
        r_lr <= w_buf_data;
      end else if (w_bu_wr_lr) begin
        r_lr <= i_bu_lr_data;
      end
      if (w_entry_wr && (w_buf_sel == SPR_CTR)) begin
        r_ctr <= w_buf_data;
      end else if (w_bu_wr_ctr) begin
        r_ctr <= r_ctr - ONE;
      end
      if (w_entry_wr && (w_buf_sel == SPR_TAR)) begin
        r_tar <= w_buf_data;
      end
      r_err <= w_accept && (i_mt_sel == SPR_NONE);
    end
  end

  assign o_lr       = r_lr;
  assign o_ctr      = r_ctr;
  assign o_tar      = r_tar;
  assign err_mt_sel = r_err;

`ifdef BRANCH_SPR_ARB_PERF_EN
  logic [0:31] r_perf_hold;
  logic [0:31] r_perf_drain;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_hold  <= '0;
      r_perf_drain <= '0;
    end else begin
      if (o_bu_hold && (r_perf_hold != '1)) begin
        r_perf_hold <= r_perf_hold + 32'd1;
      end
      if ((w_state_nxt == DRAIN) && (r_state != DRAIN) && (r_perf_drain != '1)) begin
        r_perf_drain <= r_perf_drain + 32'd1;
      end
    end
  end

  assign o_perf_hold_cnt  = r_perf_hold;
  assign o_perf_drain_cnt = r_perf_drain;
`endif

endmodule

// File: tb/tb_branch_spr_arbiter.sv
// Bench for branch_spr_arbiter: cycle vectors with combinational checks inline
// and registered expectations queued until the following edge.
module tb_branch_spr_arbiter;

  localparam logic [1:0] S0  = 2'b00;
  localparam logic [1:0] LR  = 2'b01;
  localparam logic [1:0] CTR = 2'b10;
  localparam logic [1:0] TAR = 2'b11;
  localparam logic [63:0] F  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FE = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] FD = 64'hFFFF_FFFF_FFFF_FFFD;

  logic        i_clk;
  logic        i_rst;
  logic        i_bu_valid;
  logic [1:0]  i_bu_reads_spr;
  logic        i_bu_wr_lr;
  logic [63:0] i_bu_lr_data;
  logic        i_bu_wr_ctr;
  logic        o_bu_hold;
  logic        i_mt_valid;
  logic        o_mt_ready;
  logic [1:0]  i_mt_sel;
  logic [63:0] i_mt_data;
  logic [63:0] o_lr;
  logic [63:0] o_ctr;
  logic [63:0] o_tar;
  logic        err_mt_sel;
`ifdef BRANCH_SPR_ARB_PERF_EN
  logic [0:31] o_perf_hold_cnt;
  logic [0:31] o_perf_drain_cnt;
`endif

  branch_spr_arbiter #(.MAX_WAIT(4), .XLEN(64)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_bu_valid     (i_bu_valid),
    .i_bu_reads_spr (i_bu_reads_spr),
    .i_bu_wr_lr     (i_bu_wr_lr),
    .i_bu_lr_data   (i_bu_lr_data),
    .i_bu_wr_ctr    (i_bu_wr_ctr),
    .o_bu_hold      (o_bu_hold),
    .i_mt_valid     (i_mt_valid),
    .o_mt_ready     (o_mt_ready),
    .i_mt_sel       (i_mt_sel),
    .i_mt_data      (i_mt_data),
    .o_lr           (o_lr),
    .o_ctr          (o_ctr),
    .o_tar          (o_tar),
    .err_mt_sel     (err_mt_sel)
`ifdef BRANCH_SPR_ARB_PERF_EN
    ,
    .o_perf_hold_cnt  (o_perf_hold_cnt),
    .o_perf_drain_cnt (o_perf_drain_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        bv;
    logic [1:0]  rd;
    logic        wl;
    logic [63:0] ld;
    logic        wc;
    logic        mv;
    logic [1:0]  ms;
    logic [63:0] md;
    logic        chk;
    logic        hold;
    logic        ready;
    logic [63:0] lr;
    logic [63:0] ctr;
    logic [63:0] tar;
    logic        err;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] lr;
    logic [63:0] ctr;
    logic [63:0] tar;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[23];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic vec_t mk(string name, logic rst, logic bv, logic [1:0] rd,
                              logic wl, logic [63:0] ld, logic wc, logic mv,
                              logic [1:0] ms, logic [63:0] md, logic chk,
                              logic hold, logic ready, logic [63:0] lr,
                              logic [63:0] ctr, logic [63:0] tar, logic err);
    vec_t v;
    v.name = name; v.rst = rst; v.bv = bv; v.rd = rd; v.wl = wl; v.ld = ld;
    v.wc = wc; v.mv = mv; v.ms = ms; v.md = md; v.chk = chk; v.hold = hold;
    v.ready = ready; v.lr = lr; v.ctr = ctr; v.tar = tar; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge i_clk);
    i_rst          = v.rst;
    i_bu_valid     = v.bv;
    i_bu_reads_spr = v.rd;
    i_bu_wr_lr     = v.wl;
    i_bu_lr_data   = v.ld;
    i_bu_wr_ctr    = v.wc;
    i_mt_valid     = v.mv;
    i_mt_sel       = v.ms;
    i_mt_data      = v.md;
    #1;
    if (v.chk) begin
      chk({v.name, ".hold"},  {63'd0, o_bu_hold},  {63'd0, v.hold});
      chk({v.name, ".ready"}, {63'd0, o_mt_ready}, {63'd0, v.ready});
    end
    e.name = v.name; e.lr = v.lr; e.ctr = v.ctr; e.tar = v.tar; e.err = v.err;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", v.name);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".lr"},  o_lr,  e.lr);
      chk({e.name, ".ctr"}, o_ctr, e.ctr);
      chk({e.name, ".tar"}, o_tar, e.tar);
      chk({e.name, ".err"}, {63'd0, err_mt_sel}, {63'd0, e.err});
    end
  endtask

  initial begin
    i_rst = 1'b1; i_bu_valid = 1'b0; i_bu_reads_spr = S0; i_bu_wr_lr = 1'b0;
    i_bu_lr_data = '0; i_bu_wr_ctr = 1'b0; i_mt_valid = 1'b0; i_mt_sel = S0;
    i_mt_data = '0;

    //              name            rst bv rd   wl ld        wc mv ms   md        chk h  r  lr        ctr   tar       err
    tbl[0]  = mk("reset0",          1, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    0, 0, 1, 64'h0,    64'h0, 64'h0,    0);
    tbl[1]  = mk("reset1",          1, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h0,    64'h0, 64'h0,    0);
    tbl[2]  = mk("mtctr",           0, 0, S0,  0, 64'h0,    0, 1, CTR, 64'h10,   1, 0, 1, 64'h0,    64'h0, 64'h0,    0);
    tbl[3]  = mk("mtctr_vis",       0, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h0,    64'h10, 64'h0,   0);
    tbl[4]  = mk("idle",            0, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h0,    64'h10, 64'h0,   0);
    tbl[5]  = mk("mtctr0",          0, 0, S0,  0, 64'h0,    0, 1, CTR, 64'h0,    1, 0, 1, 64'h0,    64'h10, 64'h0,   0);
    tbl[6]  = mk("ctr0_vis",        0, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h0,    64'h0, 64'h0,    0);
    tbl[7]  = mk("bc_wrap",         0, 1, S0,  0, 64'h0,    1, 0, S0,  64'h0,    1, 0, 1, 64'h0,    F,     64'h0,    0);
    tbl[8]  = mk("bc_dec",          0, 1, S0,  0, 64'h0,    1, 0, S0,  64'h0,    1, 0, 1, 64'h0,    FE,    64'h0,    0);
    tbl[9]  = mk("mtlr",            0, 0, S0,  0, 64'h0,    0, 1, LR,  64'h1000, 1, 0, 1, 64'h0,    FE,    64'h0,    0);
    tbl[10] = mk("raw_hold",        0, 1, LR,  1, 64'hAAAA, 0, 0, S0,  64'h0,    1, 1, 1, 64'h1000, FE,    64'h0,    0);
    tbl[11] = mk("raw_retry",       0, 1, LR,  0, 64'hAAAA, 0, 0, S0,  64'h0,    1, 0, 1, 64'h1000, FE,    64'h0,    0);
    tbl[12] = mk("mttar",           0, 0, S0,  0, 64'h0,    0, 1, TAR, 64'h2000, 1, 0, 1, 64'h1000, FE,    64'h0,    0);
    tbl[13] = mk("both_commit",     0, 1, S0,  0, 64'h0,    1, 0, S0,  64'h0,    1, 0, 1, 64'h1000, FD,    64'h2000, 0);
    tbl[14] = mk("mt_sel00",        0, 0, S0,  0, 64'h0,    0, 1, S0,  64'hDEAD, 1, 0, 1, 64'h1000, FD,    64'h2000, 1);
    tbl[15] = mk("err_clear",       0, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h1000, FD,    64'h2000, 0);
    tbl[16] = mk("mtlr2",           0, 0, S0,  0, 64'h0,    0, 1, LR,  64'h3000, 1, 0, 1, 64'h1000, FD,    64'h2000, 0);
    tbl[17] = mk("pend_new",        0, 0, S0,  0, 64'h0,    0, 1, TAR, 64'h4000, 1, 0, 1, 64'h3000, FD,    64'h2000, 0);
    tbl[18] = mk("pend_new_vis",    0, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h3000, FD,    64'h4000, 0);
    tbl[19] = mk("mtlr3",           0, 0, S0,  0, 64'h0,    0, 1, LR,  64'h5000, 1, 0, 1, 64'h3000, FD,    64'h4000, 0);
    tbl[20] = mk("defer_noready",   0, 1, S0,  1, 64'h11,   0, 1, CTR, 64'h77,   1, 0, 0, 64'h11,   FD,    64'h4000, 0);
    tbl[21] = mk("pend_write",      0, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h5000, FD,    64'h4000, 0);
    tbl[22] = mk("no_stray",        0, 0, S0,  0, 64'h0,    0, 0, S0,  64'h0,    1, 0, 1, 64'h5000, FD,    64'h4000, 0);

    for (int i = 0; i < 23; i++) step(tbl[i]);

    // forced drain: LR entry starved by branch LR writes every cycle
    step(mk("drain_mt", 0, 0, S0, 0, 64'h0, 0, 1, LR, 64'hD0, 1, 0, 1, 64'h5000, FD, 64'h4000, 0));
    for (int k = 1; k <= 4; k++)
      step(mk($sformatf("drain_defer%0d", k), 0, 1, S0, 1, 64'h100 + 64'(k), 0, 0, S0, 64'h0,
              1, 0, 0, 64'h100 + 64'(k), FD, 64'h4000, 0));
    step(mk("drain_force", 0, 1, S0, 1, 64'h1FF, 1, 0, S0, 64'h0, 1, 1, 1, 64'hD0, FD, 64'h4000, 0));
    step(mk("drain_after", 0, 1, S0, 1, 64'h200, 0, 0, S0, 64'h0, 1, 0, 1, 64'h200, FD, 64'h4000, 0));

    // reset with an entry pending discards the entry
    step(mk("rstmid_mt",   0, 0, S0, 0, 64'h0, 0, 1, TAR, 64'hBEEF, 1, 0, 1, 64'h200, FD, 64'h4000, 0));
    step(mk("rstmid_rst",  1, 0, S0, 0, 64'h0, 0, 0, S0,  64'h0,    0, 0, 1, 64'h0,   64'h0, 64'h0,  0));
    step(mk("rstmid_idle", 0, 0, S0, 0, 64'h0, 0, 0, S0,  64'h0,    1, 0, 1, 64'h0,   64'h0, 64'h0,  0));
    step(mk("rstmid_idle2",0, 0, S0, 0, 64'h0, 0, 0, S0,  64'h0,    1, 0, 1, 64'h0,   64'h0, 64'h0,  0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
